rx_module: RTL

UART receiver and serial counterpart of the team's transmitter. It deserialises the line into frames of 6/7/8/9 data bits, with optional parity and 1-2 stop bits. The rx line is sampled on an oversample tick (OVERSAMPLE ticks per bit) from the shared baud generator. Received words, parity/framing status and overrun are presented to the register/FIFO stage through a valid/ack handshake.

---
 rtl/rx_module.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/rx_module.sv
// UART receiver: oversampled deserialiser for 6/7/8/9 data bits, optional parity, 1-2 stop bits.
// Optional macro RX_MAJORITY_VOTE_EN: each bit is decided by a 3-sample majority around the bit centre.
`timescale 1ns/1ps
module rx_module #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en,
  input  logic       rx_i,
  input  logic [3:0] data_size_i,
  input  logic       parity_size_i,
  input  logic       parity_type_i,
  input  logic [1:0] stop_size_i,
  input  logic       rx_ack_i,
  output logic [8:0] data_o,
  output logic       rx_valid_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       rx_busy_o
);

  localparam int TCW = $clog2(OVERSAMPLE);
  localparam logic [TCW-1:0] TC_MAX = TCW'(OVERSAMPLE - 1);
`ifdef RX_MAJORITY_VOTE_EN
  localparam logic [TCW-1:0] TC_DECIDE = TCW'(OVERSAMPLE / 2 + 1);
`else
  localparam logic [TCW-1:0] TC_DECIDE = TCW'(OVERSAMPLE / 2);
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic                   bit_val;
  logic                   prev_q;
  logic [TCW-1:0]         tc_q;
  logic [3:0]             bit_cnt_q;
  logic                   stop_cnt_q;
  logic [8:0]             shreg_q;
  logic [8:0]             aligned;
  logic [3:0]             n_q;
  logic                   par_en_q, par_even_q, two_stop_q;
  logic                   par_acc_q, par_err_q, frm_err_q;
  logic                   sample_pt, wrap, last_data, last_stop, commit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '1;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
  end
  assign rxs = sync_q[SYNC_STAGES-1];

`ifdef RX_MAJORITY_VOTE_EN
  logic [1:0] vote_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vote_q <= 2'b11;
    end else if (en) begin
      if (tc_q == TC_DECIDE - TCW'(2)) vote_q[0] <= rxs;
      if (tc_q == TC_DECIDE - TCW'(1)) vote_q[1] <= rxs;
    end
  end
  assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxs) | (vote_q[1] & rxs);
`else
  assign bit_val = rxs;
`endif

  assign sample_pt = (tc_q == TC_DECIDE);
  assign wrap      = (tc_q == TC_MAX);
  assign last_data = (bit_cnt_q == n_q - 4'd1);
  assign last_stop = !two_stop_q || stop_cnt_q;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state: only en ticks move the machine. A start needs a high sample before the low one.
  always_comb begin
    state_d = state_q;
    if (en) begin
      case (state_q)
        IDLE:    if (!rxs && prev_q) state_d = START;
        START: begin
          if (sample_pt && bit_val) state_d = IDLE;
          else if (wrap)            state_d = DATA;
        end
        DATA:    if (wrap && last_data) state_d = par_en_q ? PARITY : STOP;
        PARITY:  if (wrap) state_d = STOP;
        STOP:    if (sample_pt && last_stop) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs of the state machine
  always_comb begin
    rx_busy_o = (state_q != IDLE);
    commit    = en && (state_q == STOP) && sample_pt && last_stop;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q     <= 1'b1;
      tc_q       <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shreg_q    <= '0;
      n_q        <= 4'd8;
      par_en_q   <= 1'b0;
      par_even_q <= 1'b0;
      two_stop_q <= 1'b0;
      par_acc_q  <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
    end else if (en) begin
      prev_q <= rxs;
      tc_q   <= tc_q + TCW'(1);
      case (state_q)
        IDLE: begin
          tc_q <= '0;
          if (!rxs && prev_q) begin
            n_q        <= (data_size_i inside {4'd6, 4'd7, 4'd8}) ? data_size_i : 4'd9;
            par_en_q   <= parity_size_i;
            par_even_q <= parity_type_i;
            two_stop_q <= (stop_size_i == 2'd2);
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_acc_q  <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
          end
        end
        DATA: begin
          if (sample_pt) begin
            shreg_q   <= {bit_val, shreg_q[8:1]};
            par_acc_q <= par_acc_q ^ bit_val;
          end
          if (wrap) bit_cnt_q <= bit_cnt_q + 4'd1;
        end
        PARITY: if (sample_pt) par_err_q <= par_acc_q ^ bit_val ^ ~par_even_q;
        STOP: begin
          if (sample_pt && !bit_val) frm_err_q <= 1'b1;
          if (wrap) stop_cnt_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Bits enter at the MSB, so a short word sits in the top of shreg_q.
  always_comb begin
    case (n_q)
      4'd6:    aligned = {3'b000, shreg_q[8:3]};
      4'd7:    aligned = {2'b00, shreg_q[8:2]};
      4'd8:    aligned = {1'b0, shreg_q[8:1]};
      default: aligned = shreg_q;
    endcase
  end

  // Handshake: rx_valid_o rises on commit and holds data_o/flags until a cycle with rx_ack_i high;
  // a commit while valid and not acked is dropped and sets overrun_o, which only an ack with
  // rx_valid_o low clears.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_o       <= '0;
      rx_valid_o   <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      if (rx_ack_i && !rx_valid_o) overrun_o <= 1'b0;
      if (commit) begin
        if (rx_valid_o && !rx_ack_i) begin
          overrun_o <= 1'b1;
        end else begin
          data_o       <= aligned;
          parity_err_o <= par_err_q;
          frame_err_o  <= frm_err_q | ~bit_val;
          rx_valid_o   <= 1'b1;
        end
      end else if (rx_ack_i && rx_valid_o) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

endmodule
